// File: rtl/keypad_cmd_encoder_if.sv
// keypad_cmd_encoder_if: keypad pins and command bus of keypad_cmd_encoder.
// slave is the encoder side; master is the board / bench side that drives
// the keypad rows and consumes the command bus.
interface keypad_cmd_encoder_if;
  logic [3:0] row_n;      // keypad rows, active-low, pulled up
  logic [3:0] col_n;      // keypad column drive, one-hot active-low
  logic [3:0] cmd;        // command code to calc_top
  logic       cmd_valid;  // first cycle of each new code
  logic       busy;       // FSM outside SCAN

  modport master (output row_n, input col_n, cmd, cmd_valid, busy);
  modport slave  (input row_n, output col_n, cmd, cmd_valid, busy);
endinterface

// File: rtl/keypad_cmd_encoder.sv
// keypad_cmd_encoder: scans a 4x4 keypad, debounces press and release and
// emits one 4-bit calc_top command per press, held for HOLD_CYCLES cycles.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat while held).
module keypad_cmd_encoder #(
  parameter int         SCAN_DIV        = 1000,
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         HOLD_CYCLES     = 10,
  parameter int         REPEAT_CYCLES   = 250000,
  parameter logic [3:0] IDLE_CODE       = 4'b1101
) (
  input logic                 clock,
  input logic                 reset,
  keypad_cmd_encoder_if.slave kp
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One width for every counter, large enough for the biggest parameter.
  localparam int CW = $clog2(max_int(max_int(SCAN_DIV, DEBOUNCE_CYCLES),
                                     max_int(HOLD_CYCLES, REPEAT_CYCLES))) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_N    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] HOLD_N   = CW'(HOLD_CYCLES);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_N    = CW'(REPEAT_CYCLES);
`endif

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_EMIT, ST_RELEASE} state_t;

  // Counters saturate instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // (row, column) to calc_top command; row 3 column 3 has no code.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'b0001;  4'h1: return 4'b0010;
      4'h2: return 4'b0011;  4'h3: return 4'b1010;
      4'h4: return 4'b0100;  4'h5: return 4'b0101;
      4'h6: return 4'b0110;  4'h7: return 4'b1011;
      4'h8: return 4'b0111;  4'h9: return 4'b1000;
      4'hA: return 4'b1001;  4'hB: return 4'b1100;
      4'hC: return 4'b1111;  4'hD: return 4'b0000;
      4'hE: return 4'b1110;  default: return IDLE_CODE;
    endcase
  endfunction

  state_t        state_reg, state_next;
  logic [3:0]    sync1_reg, row_s_reg;
  logic [1:0]    col_reg, col_next;
  logic [1:0]    row_reg, row_next;
  logic [CW-1:0] div_reg, div_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]    cmd_reg, cmd_next;
  logic          valid_reg, valid_next;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CW-1:0] rep_reg, rep_next, rep_inc;
`endif

  logic [1:0] low_row;
  logic       key_low;
  logic       unused_key;
  logic [3:0] key_code;

  assign cnt_inc    = sat_inc(cnt_reg);
  assign key_low    = ~row_s_reg[row_reg];
  assign unused_key = (row_reg == 2'd3) && (col_reg == 2'd3);
  assign key_code   = map_key(row_reg, col_reg);
`ifdef KEYPAD_AUTOREPEAT_EN
  assign rep_inc    = sat_inc(rep_reg);
`endif

  assign kp.col_n     = ~(4'b0001 << col_reg);
  assign kp.cmd       = cmd_reg;
  assign kp.cmd_valid = valid_reg;
  assign kp.busy      = (state_reg != ST_SCAN);

  // Lowest-numbered row currently reading low.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s_reg[i]) low_row = 2'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= ST_SCAN;
    else        state_reg <= state_next;
  end

  // Next state plus scan position and counters.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    div_next   = div_reg;
    cnt_next   = cnt_reg;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_next   = rep_reg;
`endif
    case (state_reg)
      ST_SCAN: begin
        cnt_next = '0;
        if (div_reg >= DIV_LAST) begin
          div_next = '0;
          if (row_s_reg != 4'hF) begin
            state_next = ST_DEBOUNCE;
            row_next   = low_row;
          end else begin
            col_next = col_reg + 2'd1;
          end
        end else begin
          div_next = sat_inc(div_reg);
        end
      end
      ST_DEBOUNCE: begin
        if (key_low) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= DEB_N) begin
            cnt_next   = '0;
            state_next = unused_key ? ST_RELEASE : ST_EMIT;
          end
        end else begin
          // Bounce: resume scanning from the column after this one.
          state_next = ST_SCAN;
          col_next   = col_reg + 2'd1;
          div_next   = '0;
          cnt_next   = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next = '0;
`endif
      end
      ST_EMIT: begin
        cnt_next = cnt_inc;
        if (cnt_inc >= HOLD_N) begin
          cnt_next   = '0;
          state_next = ST_RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_next = '0;
`endif
      end
      default: begin  // ST_RELEASE
        if (row_s_reg == 4'hF) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= DEB_N) begin
            state_next = ST_SCAN;
            col_next   = col_reg + 2'd1;
            div_next   = '0;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = '0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        // Repeat timer runs only while the captured key itself is held.
        if (key_low && !unused_key) begin
          rep_next = rep_inc;
          if (rep_inc >= REP_N) begin
            rep_next   = '0;
            cnt_next   = '0;
            state_next = ST_EMIT;
          end
        end else begin
          rep_next = '0;
        end
`endif
      end
    endcase
  end

  // Registered outputs: load the code on EMIT entry, idle it on EMIT exit.
  always_comb begin
    cmd_next   = cmd_reg;
    valid_next = 1'b0;
    if (state_next == ST_EMIT && state_reg != ST_EMIT) begin
      cmd_next   = key_code;
      valid_next = 1'b1;
    end else if (state_reg == ST_EMIT && state_next != ST_EMIT) begin
      cmd_next = IDLE_CODE;
    end
  end

  // Synchronizer, scan datapath, counters and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 4'hF;
      row_s_reg <= 4'hF;
      col_reg   <= 2'd0;
      row_reg   <= 2'd0;
      div_reg   <= '0;
      cnt_reg   <= '0;
      cmd_reg   <= IDLE_CODE;
      valid_reg <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_reg   <= '0;
`endif
    end else begin
      sync1_reg <= kp.row_n;
      row_s_reg <= sync1_reg;
      col_reg   <= col_next;
      row_reg   <= row_next;
      div_reg   <= div_next;
      cnt_reg   <= cnt_next;
      cmd_reg   <= cmd_next;
      valid_reg <= valid_next;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_reg   <= rep_next;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_cmd_encoder.sv
// tb_keypad_cmd_encoder: keypad matrix model plus scoreboard of expected
// command codes and their cycle of appearance.
module tb_keypad_cmd_encoder;
  localparam int         SCAN_DIV = 4;
  localparam int         DEB      = 8;
  localparam int         HOLD     = 10;
  localparam int         REP      = 40;
  localparam logic [3:0] IDLE     = 4'b1101;
  // Key pressed on the first cycle A of its column dwell: row_s is low from
  // A+2, sampled at A+SCAN_DIV-1, cmd_valid DEB+1 cycles after that.
  localparam int         LAT      = (SCAN_DIV - 1) + DEB + 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  keypad_cmd_encoder_if kp();

  keypad_cmd_encoder #(
    .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .IDLE_CODE(IDLE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .kp(kp)
  );

  // Key matrix: a pressed key pulls its row low while its column is driven.
  logic [15:0] keys = '0;
  always_comb begin
    kp.row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.col_n[c]) kp.row_n[r] = 1'b0;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on each pulse, checks hold length.
  logic       hold_active = 1'b0;
  int         hold_len = 0;
  logic [3:0] hold_code = IDLE;
  exp_t       mon_e;
  always @(negedge clock) begin
    if (!reset) begin
      hold_active = 1'b0;
      hold_len    = 0;
    end else if (kp.cmd_valid) begin
      $display("cycle %0d: cmd_valid cmd=%b", cyc, kp.cmd);
      if (hold_active) check("hold_len_cut", hold_len, HOLD);
      if (sb.size() == 0) begin
        check("spurious_valid", int'(kp.cmd_valid), 0);
      end else begin
        mon_e = sb.pop_front();
        check("cmd_code", int'(kp.cmd), int'(mon_e.code));
        check("latency", cyc, mon_e.cyc);
      end
      hold_active = 1'b1;
      hold_len    = 1;
      hold_code   = kp.cmd;
    end else if (hold_active) begin
      if (kp.cmd == hold_code && hold_len < HOLD) begin
        hold_len++;
      end else begin
        check("hold_len", hold_len, HOLD);
        check("cmd_idle_after", int'(kp.cmd), int'(IDLE));
        hold_active = 1'b0;
      end
    end else begin
      check("cmd_idle", int'(kp.cmd), int'(IDLE));
    end
  end

  task automatic push_exp(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Return on the negedge of the first cycle of column c's dwell.
  task automatic align_col(input int c);
    logic [3:0] tgt;
    logic [3:0] prev;
    logic       ok;
    int         n;
    tgt  = ~(4'b0001 << c);
    prev = kp.col_n;
    ok   = 1'b0;
    n    = 0;
    while (!ok && n < 100) begin
      @(negedge clock);
      n++;
      ok   = (kp.col_n == tgt) && (prev != tgt);
      prev = kp.col_n;
    end
    if (!ok) check("align_timeout", int'(kp.col_n), int'(tgt));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (kp.busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("idle_wait", int'(kp.busy), 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic tap(input int r, input int c, input logic [3:0] code, input int hold);
    align_col(c);
    keys[r*4+c] = 1'b1;
    push_exp(code, cyc + LAT);
    repeat (hold) @(negedge clock);
    keys[r*4+c] = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_col;

    // Reset state with all rows high.
    repeat (3) @(negedge clock);
    check("rst_col_n", int'(kp.col_n), 4'b1110);
    check("rst_cmd", int'(kp.cmd), int'(IDLE));
    check("rst_cmd_valid", int'(kp.cmd_valid), 0);
    check("rst_busy", int'(kp.busy), 0);
    reset = 1'b1;
    // Cycle of release counts as dwell cycle 0 of column 0.
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check("col_rotation", int'(kp.col_n), int'(exp_col));
    end

    // "1", "2", "3", "+", "1", "=".
    tap(0, 0, 4'b0001, 40);
    tap(0, 1, 4'b0010, 40);
    tap(0, 2, 4'b0011, 40);
    tap(0, 3, 4'b1010, 40);
    tap(0, 0, 4'b0001, 40);
    tap(3, 2, 4'b1110, 40);

    // Bounce: row 1 on column 1 for 3 cycles; DEBOUNCE entered at A+4,
    // row_s goes high at A+5 and SCAN resumes at A+6.
    align_col(1);
    keys[5] = 1'b1;
    repeat (3) @(negedge clock);
    keys[5] = 1'b0;
    @(negedge clock);
    check("bounce_busy_hi", int'(kp.busy), 1);
    repeat (6) @(negedge clock);
    check("bounce_busy_lo", int'(kp.busy), 0);
    check("bounce_cmd", int'(kp.cmd), int'(IDLE));

    // Rows 0 and 2 on column 2: lowest row wins -> "3".
    align_col(2);
    keys[2]  = 1'b1;
    keys[10] = 1'b1;
    push_exp(4'b0011, cyc + LAT);
    repeat (40) @(negedge clock);
    keys[2]  = 1'b0;
    keys[10] = 1'b0;
    wait_idle();

    // Unused key (3,3): no pulse, busy from A+4 until release.
    align_col(3);
    keys[15] = 1'b1;
    repeat (4) @(negedge clock);
    for (int k = 0; k < 36; k++) begin
      check("unused_busy", int'(kp.busy), 1);
      @(negedge clock);
    end
    keys[15] = 1'b0;
    wait_idle();

    // Reset during the 5th EMIT cycle of "9".
    align_col(2);
    keys[10] = 1'b1;
    push_exp(4'b1001, cyc + LAT);
    repeat (LAT + 4) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("midrst_cmd", int'(kp.cmd), int'(IDLE));
    check("midrst_cmd_valid", int'(kp.cmd_valid), 0);
    check("midrst_busy", int'(kp.busy), 0);
    check("midrst_col_n", int'(kp.col_n), 4'b1110);
    keys[10] = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (60) @(negedge clock);
    check("midrst_sb", sb.size(), 0);

    // Hold backspace for 200 cycles from dwell start A (row_s low A+2..A+201).
    align_col(0);
    keys[12] = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
    // Pulses at A+12, +62, +112, +162; a fifth would need the key held
    // through A+211.
    for (int k = 0; k < 4; k++) push_exp(4'b1111, cyc + LAT + k * (REP + HOLD));
`else
    push_exp(4'b1111, cyc + LAT);
`endif
    repeat (200) @(negedge clock);
    keys[12] = 1'b0;
    wait_idle();
    repeat (20) @(negedge clock);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
